pixel_frame_capture: RTL and testbench
======================================

# pixel_frame_capture

Downstream consumer of the dual-channel ADC sampling stage. Clocked by `sensor_clk`, it captures one 12-bit sample per channel per pixel for a full line of `NUM_PIXELS` pixels into two line buffers and tracks the peak value and peak index of each channel, which give the optical spot position used for force estimation. A registered read port lets the host interface drain the stored line once capture completes.

## Interface
- `NUM_PIXELS`, 128: pixels per line; must satisfy 2 ≤ NUM_PIXELS ≤ 2^IDX_W.
- `IDX_W`, 7: pixel index / address width.
- `DATA_W`, 12: sample width per channel.
- `SKIP`, 2: `sensor_clk` cycles between `frame_start` and the cycle that carries pixel 0; range 0..15.

Ports:
- `sensor_clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `frame_start`  in  1  one-cycle pulse marking the start of a line; synchronous to `sensor_clk`.
- `pdata1`  in  DATA_W  channel-1 pixel sample; sampled on every capture cycle.
- `pdata2`  in  DATA_W  channel-2 pixel sample.
- `clr_overrun`  in  1  synchronous clear of `overrun`.
- `rd_en`  in  1  read request.
- `rd_addr`  in  IDX_W  pixel index to read.
- `rd_data1`  out  DATA_W  registered channel-1 read data.
- `rd_data2`  out  DATA_W  registered channel-2 read data.
- `rd_valid`  out  1  read data valid.
- `busy`  out  1  high in DELAY and CAPTURE.
- `frame_done`  out  1  one-cycle pulse; peak outputs updated.
- `peak_val1` / `peak_val2`  out  DATA_W  maximum sample of the last completed line.
- `peak_idx1` / `peak_idx2`  out  IDX_W  index of that maximum.
- `overrun`  out  1  sticky flag: a `frame_start` arrived while `busy`.

## Operation
- FSM states: IDLE, DELAY, CAPTURE, DONE.
  - IDLE → DELAY on `frame_start`; if SKIP = 0, go directly IDLE → CAPTURE.
  - DELAY: counts SKIP−1 down to 0, then → CAPTURE.
  - CAPTURE: each cycle writes `pdata1`/`pdata2` to address `pix_cnt` and increments `pix_cnt` from 0. After index NUM_PIXELS−1 is written → DONE.
  - DONE: one cycle, then → IDLE.
- Peak tracking during CAPTURE, per channel:
  - At pixel 0, the running max is loaded unconditionally.
  - After that, the running max is replaced only when the sample is strictly greater (unsigned compare). On a tie, the lowest index wins.
- In DONE, the running max and index are copied to the `peak_*` outputs and `frame_done` is asserted. The outputs hold until the next DONE.
- A `frame_start` while in DELAY, CAPTURE or DONE is ignored and sets `overrun`.
  - `overrun` is cleared only by `reset` or `clr_overrun`.
  - If `clr_overrun` and a new overrun event occur in the same cycle, set wins.
- Read port:
  - `rd_en` while in IDLE returns the buffer word one cycle later with `rd_valid` = 1.
  - `rd_en` in any other state gives `rd_valid` = 0 and leaves `rd_data*` unchanged.
  - Addresses ≥ NUM_PIXELS return 0 with `rd_valid` = 1.
- Reset values: FSM = IDLE, all counters 0, and all outputs 0 (`busy`, `frame_done`, `rd_valid`, `overrun`, `peak_*`, `rd_data*`). Buffer contents are not reset.
- Reset mid-capture aborts the line. Peak outputs are 0 and buffer contents are undefined until the next complete line.

## Timing
- `frame_start` at cycle T:
  - `busy` is high from T+1.
  - Pixel i is sampled at cycle T+1+SKIP+i.
  - DONE is at T+1+SKIP+NUM_PIXELS, and `frame_done` and `peak_*` are visible at that cycle's register outputs.
  - `busy` is low in DONE.
- Read latency is 1 cycle. `rd_en` at cycle R gives `rd_valid` at R+1.
- Back-to-back lines: the earliest accepted `frame_start` is the cycle after DONE. With default parameters, line period ≥ NUM_PIXELS+SKIP+2 = 132 cycles.
- `frame_start` in the DONE cycle is an overrun.

## Configuration
- `PIXEL_SUM_EN` defined:
  - Adds outputs `sum1` and `sum2`, each DATA_W+IDX_W (19) bits unsigned. Each is the sum of all samples in the line, accumulated during CAPTURE without overflow, latched in DONE, and reset to 0.
  - Used for intensity normalisation.
- Not defined: the ports and accumulators are absent; all other behaviour is identical.

## Test plan
- Ramp line: `pdata1` = i, `pdata2` = 4095−i, SKIP = 2, `frame_start` at cycle 10.
  - `frame_done` at cycle 141.
  - `peak_val1` = 127, `peak_idx1` = 127; `peak_val2` = 4095, `peak_idx2` = 0.
  - Readback of address 5 gives 5 / 4090 one cycle after `rd_en`.
- Tie: `pdata1` = 0x800 at pixels 20 and 90, and 0x100 elsewhere.
  - `peak_val1` = 0x800, `peak_idx1` = 20.
- Overrun: second `frame_start` 50 cycles after the first.
  - It is ignored, `overrun` = 1, and the first line completes normally.
  - `clr_overrun` then returns `overrun` to 0.
- Reset mid-line: assert `reset` at pixel 64.
  - All outputs are 0 and the FSM is in IDLE.
  - A new line with constant 0x0AB gives `peak_val` = 0x0AB, `peak_idx` = 0.
- Read while busy: `rd_en` during CAPTURE gives `rd_valid` = 0. `rd_addr` = 200 in IDLE with NUM_PIXELS = 128 gives `rd_data` = 0 and `rd_valid` = 1.
- With `PIXEL_SUM_EN`: constant 4095 on both channels gives `sum1` = `sum2` = 524160.

Source files
------------

// File: rtl/pixel_frame_capture_if.sv
// Line-capture bus: sample inputs, host read port and line status.
// PIXEL_SUM_EN adds the per-line sum outputs.
interface pixel_frame_capture_if #(
   parameter int DATA_W = 12,
   parameter int IDX_W  = 7
);
   logic              frame_start;
   logic [DATA_W-1:0] pdata1;
   logic [DATA_W-1:0] pdata2;
   logic              clr_overrun;
   logic              rd_en;
   logic [IDX_W-1:0]  rd_addr;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              rd_valid;
   logic              busy;
   logic              frame_done;
   logic [DATA_W-1:0] peak_val1;
   logic [DATA_W-1:0] peak_val2;
   logic [IDX_W-1:0]  peak_idx1;
   logic [IDX_W-1:0]  peak_idx2;
   logic              overrun;
`ifdef PIXEL_SUM_EN
   logic [DATA_W+IDX_W-1:0] sum1;
   logic [DATA_W+IDX_W-1:0] sum2;
`endif

   modport master (
`ifdef PIXEL_SUM_EN
      input  sum1, sum2,
`endif
      output frame_start, pdata1, pdata2,
      output clr_overrun, rd_en, rd_addr,
      input  rd_data1, rd_data2, rd_valid,
      input  busy, frame_done, overrun,
      input  peak_val1, peak_val2,
      input  peak_idx1, peak_idx2
   );

   modport slave (
`ifdef PIXEL_SUM_EN
      output sum1, sum2,
`endif
      input  frame_start, pdata1, pdata2,
      input  clr_overrun, rd_en, rd_addr,
      output rd_data1, rd_data2, rd_valid,
      output busy, frame_done, overrun,
      output peak_val1, peak_val2,
      output peak_idx1, peak_idx2
   );
endinterface

// File: rtl/pixel_frame_capture.sv
// Dual-channel line capture with peak tracking and registered readback.
// Optional PIXEL_SUM_EN adds per-line sample sums.
module pixel_frame_capture #(
   parameter int NUM_PIXELS = 128,
   parameter int IDX_W      = 7,
   parameter int DATA_W     = 12,
   parameter int SKIP       = 2
) (
   input  logic sensor_clk,
   input  logic reset,
   pixel_frame_capture_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE, DELAY, CAPTURE, DONE
   } state_t;

   localparam logic [3:0] DLY0 =
      4'(SKIP > 0 ? SKIP - 1 : 0);
   localparam logic [IDX_W-1:0] LAST =
      IDX_W'(NUM_PIXELS - 1);
   localparam logic [IDX_W:0] NPX =
      (IDX_W+1)'(NUM_PIXELS);

   state_t state, state_nxt;
   logic [3:0] dly;
   logic [IDX_W-1:0] pix_cnt;
   logic [DATA_W-1:0] max1, max2, nmax1, nmax2;
   logic [IDX_W-1:0] mi1, mi2, nmi1, nmi2;
   logic cap, last, idle, oob;

   logic [DATA_W-1:0] mem1 [2**IDX_W];
   logic [DATA_W-1:0] mem2 [2**IDX_W];

   assign idle = (state == IDLE);
   assign cap  = (state == CAPTURE);
   assign last = cap && (pix_cnt == LAST);
   assign oob  = ({1'b0, bus.rd_addr} >= NPX);

   assign bus.busy =
      (state == DELAY) || (state == CAPTURE);
   assign bus.frame_done = (state == DONE);

   always_ff @(posedge sensor_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (bus.frame_start)
               state_nxt = (SKIP == 0) ? CAPTURE : DELAY;
         DELAY:
            if (dly == 4'd0) state_nxt = CAPTURE;
         CAPTURE:
            if (last) state_nxt = DONE;
         DONE:
            state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   // pixel 0 always loads; later only a strictly larger sample wins
   always_comb begin
      nmax1 = max1;
      nmi1  = mi1;
      nmax2 = max2;
      nmi2  = mi2;
      if (pix_cnt == '0 || bus.pdata1 > max1) begin
         nmax1 = bus.pdata1;
         nmi1  = pix_cnt;
      end
      if (pix_cnt == '0 || bus.pdata2 > max2) begin
         nmax2 = bus.pdata2;
         nmi2  = pix_cnt;
      end
   end

   always_ff @(posedge sensor_clk or posedge reset) begin
      if (reset) begin
         dly           <= '0;
         pix_cnt       <= '0;
         max1          <= '0;
         max2          <= '0;
         mi1           <= '0;
         mi2           <= '0;
         bus.peak_val1 <= '0;
         bus.peak_val2 <= '0;
         bus.peak_idx1 <= '0;
         bus.peak_idx2 <= '0;
      end else begin
         if (idle && bus.frame_start)
            dly <= DLY0;
         else if (state == DELAY)
            dly <= dly - 4'd1;
         if (cap) begin
            pix_cnt <= last ? '0 : pix_cnt + 1'b1;
            max1    <= nmax1;
            max2    <= nmax2;
            mi1     <= nmi1;
            mi2     <= nmi2;
         end
         if (last) begin
            bus.peak_val1 <= nmax1;
            bus.peak_val2 <= nmax2;
            bus.peak_idx1 <= nmi1;
            bus.peak_idx2 <= nmi2;
         end
      end
   end

   always_ff @(posedge sensor_clk or posedge reset) begin
      if (reset)
         bus.overrun <= 1'b0;
      else if (bus.frame_start && !idle)
         bus.overrun <= 1'b1;
      else if (bus.clr_overrun)
         bus.overrun <= 1'b0;
   end

   always_ff @(posedge sensor_clk) begin
      if (cap) begin
         mem1[pix_cnt] <= bus.pdata1;
         mem2[pix_cnt] <= bus.pdata2;
      end
   end

   always_ff @(posedge sensor_clk or posedge reset) begin
      if (reset) begin
         bus.rd_valid <= 1'b0;
         bus.rd_data1 <= '0;
         bus.rd_data2 <= '0;
      end else begin
         bus.rd_valid <= bus.rd_en && idle;
         if (bus.rd_en && idle) begin
            bus.rd_data1 <= oob ? '0 : mem1[bus.rd_addr];
            bus.rd_data2 <= oob ? '0 : mem2[bus.rd_addr];
         end
      end
   end

`ifdef PIXEL_SUM_EN
   localparam int SUM_W = DATA_W + IDX_W;
   logic [SUM_W-1:0] acc1, acc2, nacc1, nacc2;

   assign nacc1 = (pix_cnt == '0 ? '0 : acc1)
                + SUM_W'(bus.pdata1);
   assign nacc2 = (pix_cnt == '0 ? '0 : acc2)
                + SUM_W'(bus.pdata2);

   always_ff @(posedge sensor_clk or posedge reset) begin
      if (reset) begin
         acc1     <= '0;
         acc2     <= '0;
         bus.sum1 <= '0;
         bus.sum2 <= '0;
      end else begin
         if (cap) begin
            acc1 <= nacc1;
            acc2 <= nacc2;
         end
         if (last) begin
            bus.sum1 <= nacc1;
            bus.sum2 <= nacc2;
         end
      end
   end
`else
   // no line sums in this build
`endif

endmodule

// File: tb/tb_pixel_frame_capture.sv
// Scoreboard bench: stimulus pushes expected peaks and read data,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_pixel_frame_capture;
   localparam int N  = 128;
   localparam int IW = 8;
   localparam int DW = 12;
   localparam int SK = 2;

   logic sensor_clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   pixel_frame_capture_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

   pixel_frame_capture #(
      .NUM_PIXELS(N), .IDX_W(IW),
      .DATA_W(DW), .SKIP(SK)
   ) dut (
      .sensor_clk(sensor_clk),
      .reset(reset),
      .bus(bus.slave)
   );

   always #5 sensor_clk = ~sensor_clk;
   always @(posedge sensor_clk) cyc <= cyc + 1;

   typedef struct {
      int v1, i1, v2, i2, cyc;
      longint s1, s2;
   } pk_t;
   typedef struct { int d1, d2; } rd_t;

   pk_t pq[$];
   rd_t rq[$];
   pk_t pe;
   rd_t re;

   logic [DW-1:0] p1 [N];
   logic [DW-1:0] p2 [N];
   logic [DW-1:0] m1 [N];
   logic [DW-1:0] m2 [N];
   bit mem_ok = 0;

   task automatic chk(string nm, logic [63:0] act,
                      logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d",
                  nm, act, exp);
      end
   endtask

   always @(negedge sensor_clk) begin
      if (!reset) begin
         if (bus.frame_done) begin
            if (pq.size() == 0) begin
               chk("unexpected frame_done", 1, 0);
            end else begin
               pe = pq.pop_front();
               chk("done_cycle", cyc, pe.cyc);
               chk("peak_val1", bus.peak_val1, pe.v1);
               chk("peak_idx1", bus.peak_idx1, pe.i1);
               chk("peak_val2", bus.peak_val2, pe.v2);
               chk("peak_idx2", bus.peak_idx2, pe.i2);
`ifdef PIXEL_SUM_EN
               chk("sum1", bus.sum1, pe.s1);
               chk("sum2", bus.sum2, pe.s2);
`endif
            end
         end
         if (bus.rd_valid) begin
            if (rq.size() == 0) begin
               chk("unexpected rd_valid", 1, 0);
            end else begin
               re = rq.pop_front();
               chk("rd_data1", bus.rd_data1, re.d1);
               chk("rd_data2", bus.rd_data2, re.d2);
            end
         end
      end
   end

   function automatic pk_t model(int t);
      pk_t e;
      logic [DW-1:0] mq[$];
      int iq[$];
      mq = p1.max();
      iq = p1.find_first_index(x) with (x == mq[0]);
      e.v1 = int'(mq[0]);
      e.i1 = iq[0];
      mq = p2.max();
      iq = p2.find_first_index(x) with (x == mq[0]);
      e.v2 = int'(mq[0]);
      e.i2 = iq[0];
      e.s1 = p1.sum() with (longint'(item));
      e.s2 = p2.sum() with (longint'(item));
      e.cyc = t + 1 + SK + N;
      return e;
   endfunction

   task automatic fill(int kind);
      for (int i = 0; i < N; i++) begin
         case (kind)
            0: begin
               p1[i] = DW'(i);
               p2[i] = DW'(4095 - i);
            end
            1: begin
               p1[i] = (i == 20 || i == 90) ? 12'h800 : 12'h100;
               p2[i] = DW'($urandom_range(0, 7));
            end
            2: begin
               p1[i] = 12'h0AB;
               p2[i] = 12'h0AB;
            end
            3: begin
               p1[i] = DW'($urandom);
               p2[i] = DW'($urandom);
            end
            4: begin
               p1[i] = DW'($urandom_range(0, 15));
               p2[i] = DW'($urandom_range(0, 15));
            end
            default: begin
               p1[i] = 12'hFFF;
               p2[i] = 12'hFFF;
            end
         endcase
      end
   endtask

   task automatic line(int kind, int ovr, int abort, int brd);
      int t;
      fill(kind);
      @(posedge sensor_clk); #1;
      t = cyc;
      bus.frame_start = 1'b1;
      if (abort < 0) pq.push_back(model(t));
      @(posedge sensor_clk); #1;
      bus.frame_start = 1'b0;
      chk("busy_after_start", bus.busy, 1);
      repeat (SK) @(posedge sensor_clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (i == abort) begin
            reset = 1'b1;
            #2;
            chk("abort_busy", bus.busy, 0);
            chk("abort_done", bus.frame_done, 0);
            chk("abort_peak1", bus.peak_val1, 0);
            chk("abort_pidx2", bus.peak_idx2, 0);
            chk("abort_rd_valid", bus.rd_valid, 0);
            chk("abort_rd_data1", bus.rd_data1, 0);
            chk("abort_overrun", bus.overrun, 0);
            @(posedge sensor_clk); #1;
            reset = 1'b0;
            mem_ok = 0;
            return;
         end
         bus.pdata1 = p1[i];
         bus.pdata2 = p2[i];
         bus.frame_start = (ovr > 0 && i == ovr - 1 - SK);
         if (i == brd) begin
            bus.rd_en = 1'b1;
            bus.rd_addr = IW'($urandom_range(0, N - 1));
         end
         @(posedge sensor_clk); #1;
         if (i == brd) begin
            chk("rd_valid_busy", bus.rd_valid, 0);
            bus.rd_en = 1'b0;
         end
      end
      bus.frame_start = 1'b0;
      chk("busy_in_done", bus.busy, 0);
      m1 = p1;
      m2 = p2;
      mem_ok = 1;
      @(posedge sensor_clk); #1;
   endtask

   task automatic rd(int a);
      rd_t e;
      bus.rd_en = 1'b1;
      bus.rd_addr = IW'(a);
      e.d1 = (a < N) ? int'(m1[a]) : 0;
      e.d2 = (a < N) ? int'(m2[a]) : 0;
      rq.push_back(e);
      @(posedge sensor_clk); #1;
      bus.rd_en = 1'b0;
   endtask

   task automatic rand_reads(int n);
      for (int k = 0; k < n; k++)
         rd(int'($urandom_range(0, 255)));
      @(posedge sensor_clk); #1;
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.pdata1 = '0;
      bus.pdata2 = '0;
      bus.clr_overrun = 1'b0;
      bus.rd_en = 1'b0;
      bus.rd_addr = '0;
      repeat (3) @(posedge sensor_clk);
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_overrun", bus.overrun, 0);
      chk("rst_peak_val1", bus.peak_val1, 0);
      chk("rst_peak_idx2", bus.peak_idx2, 0);
      chk("rst_rd_data2", bus.rd_data2, 0);
      reset = 1'b0;
      while (cyc < 9) @(posedge sensor_clk);
      #1;

      line(0, 0, -1, -1);
      rd(5);
      rd(200);
      rand_reads(6);

      line(1, 0, -1, -1);
      rand_reads(4);
      for (int k = 0; k < 3; k++) begin
         line(3 + (k % 2), 0, -1, -1);
         rand_reads(4);
      end

      chk("overrun_before", bus.overrun, 0);
      line(3, 50, -1, 10);
      chk("overrun_set", bus.overrun, 1);
      bus.clr_overrun = 1'b1;
      @(posedge sensor_clk); #1;
      bus.clr_overrun = 1'b0;
      chk("overrun_cleared", bus.overrun, 0);
      rand_reads(4);

      line(3, 0, 64, -1);
      line(2, 0, -1, -1);
      rd(0);
      rd(N - 1);
      line(5, 0, -1, -1);
      rand_reads(4);

      repeat (5) @(posedge sensor_clk);
      #1;
      chk("pending_peaks", pq.size(), 0);
      chk("pending_reads", rq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
